// File: rtl/xsleenacore_map_scroll_pkg.sv
// Shared constants for the MAP layer scroll generator.
// Register indices and scroll register widths.
package xsleenacore_scroll_pkg;

   localparam int XS_W = 9;
   localparam int YS_W = 8;

   localparam logic [1:0] SCR_XLO = 2'd0;
   localparam logic [1:0] SCR_XHI = 2'd1;
   localparam logic [1:0] SCR_Y   = 2'd2;

endpackage

// File: rtl/xsleenacore_map_scroll_if.sv
// CPU register bus into the scroll generator.
// The CPU side drives; the scroll block listens.
interface xsleenacore_map_scroll_if;

   logic       SCRSELn;
   logic       WDn;
   logic [1:0] AB;
   logic [7:0] DB_in;

   modport master (
      output SCRSELn,
      output WDn,
      output AB,
      output DB_in
   );

   modport slave (
      input SCRSELn,
      input WDn,
      input AB,
      input DB_in
   );

endinterface

// File: rtl/xsleenacore_map_scroll_edge_det.sv
// Single-bit edge detector with a configurable history reset value.
// The first clock after reset only loads history, so a level held
// through reset release is never mistaken for an edge.
module xsleenacore_edge_det #(
   parameter bit RISE    = 1'b1,
   parameter bit RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic pulse
);

   logic prev;
   logic armed;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev  <= RST_VAL;
         armed <= 1'b0;
      end else begin
         prev  <= d;
         armed <= 1'b1;
      end
   end

   assign pulse = armed & (RISE ? (d & ~prev) : (~d & prev));

endmodule

// File: rtl/xsleenacore_map_scroll.sv
// MAP layer scroll position generator: double-buffered X/Y scroll,
// committed at VBLANK and added to the raw beam counters.
module xsleenacore_map_scroll
   import xsleenacore_scroll_pkg::*;
#(
   parameter logic [XS_W-1:0] XS_RESET = 9'h000,
   parameter logic [YS_W-1:0] YS_RESET = 8'h00
) (
   input  logic                  clk,
   input  logic                  RESETn,
   xsleenacore_map_scroll_if.slave cpu,
   input  logic                  PIXCEN,
   input  logic [8:0]            HN,
   input  logic [7:0]            VN,
   input  logic                  VBLANK,
   input  logic                  FLIP,
   output logic [5:0]            DHPOS,
   output logic [1:0]            HPOS,
   output logic                  HFINE,
   output logic [7:0]            DVPOS,
   output logic                  COMMIT
);

   logic            wd_fall;
   logic            vb_rise;
   logic            wr;
   logic [XS_W-1:0] xs_sh;
   logic [YS_W-1:0] ys_sh;
   logic [XS_W-1:0] xs_act;
   logic [YS_W-1:0] ys_act;
   logic [8:0]      hsrc;
   logic [7:0]      vsrc;
   logic [8:0]      x_sum;
   logic [7:0]      y_sum;
   logic [8:0]      x_q;

   xsleenacore_edge_det #(
      .RISE    (1'b0),
      .RST_VAL (1'b1)
   ) u_wd_det (
      .clk   (clk),
      .rst_n (RESETn),
      .d     (cpu.WDn),
      .pulse (wd_fall)
   );

   xsleenacore_edge_det #(
      .RISE    (1'b1),
      .RST_VAL (1'b0)
   ) u_vb_det (
      .clk   (clk),
      .rst_n (RESETn),
      .d     (VBLANK),
      .pulse (vb_rise)
   );

   assign wr = wd_fall & ~cpu.SCRSELn;

   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         xs_sh <= XS_RESET;
         ys_sh <= YS_RESET;
      end else if (wr) begin
         unique case (1'b1)
            (cpu.AB == SCR_XLO): xs_sh[7:0] <= cpu.DB_in;
            (cpu.AB == SCR_XHI): xs_sh[8]   <= cpu.DB_in[0];
            (cpu.AB == SCR_Y):   ys_sh      <= cpu.DB_in;
            default: ;
         endcase
      end
   end

   // Commit reads shadow before a same-clock write lands in it.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         xs_act <= XS_RESET;
         ys_act <= YS_RESET;
         COMMIT <= 1'b0;
      end else begin
         COMMIT <= vb_rise;
         if (vb_rise) begin
            xs_act <= xs_sh;
            ys_act <= ys_sh;
         end
      end
   end

   assign hsrc  = FLIP ? ~HN : HN;
   assign vsrc  = FLIP ? ~VN : VN;
   assign x_sum = hsrc + xs_act;
   assign y_sum = vsrc + ys_act;

   // Y is latched only at line start so it stays fixed across a line.
   always_ff @(posedge clk or negedge RESETn) begin
      if (!RESETn) begin
         x_q   <= '0;
         DVPOS <= '0;
      end else if (PIXCEN) begin
         x_q <= x_sum;
         if (hsrc == 9'd0)
            DVPOS <= y_sum;
      end
   end

   assign DHPOS = x_q[8:3];
   assign HPOS  = x_q[2:1];
   assign HFINE = x_q[0];

endmodule

// File: tb/tb_xsleenacore_map_scroll.sv
// Scoreboard bench for the MAP scroll generator: a behavioural
// frame model predicts every clock, a monitor compares the DUT.
module tb_xsleenacore_map_scroll;

   typedef struct {
      int x;
      int y;
      int c;
   } exp_t;

   logic       clk;
   logic       RESETn;
   logic       PIXCEN;
   logic [8:0] HN;
   logic [7:0] VN;
   logic       VBLANK;
   logic       FLIP;
   logic [5:0] DHPOS;
   logic [1:0] HPOS;
   logic       HFINE;
   logic [7:0] DVPOS;
   logic       COMMIT;

   xsleenacore_map_scroll_if cpu ();

   xsleenacore_map_scroll dut (
      .clk    (clk),
      .RESETn (RESETn),
      .cpu    (cpu.slave),
      .PIXCEN (PIXCEN),
      .HN     (HN),
      .VN     (VN),
      .VBLANK (VBLANK),
      .FLIP   (FLIP),
      .DHPOS  (DHPOS),
      .HPOS   (HPOS),
      .HFINE  (HFINE),
      .DVPOS  (DVPOS),
      .COMMIT (COMMIT)
   );

   int checks   = 0;
   int failures = 0;

   exp_t exp_q[$];

   int m_sxs, m_sys, m_xs, m_ys;
   int m_x, m_y;
   bit m_pwd, m_pvb, m_first;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(string name, int got, int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   task automatic model_reset();
      m_sxs   = 0;
      m_sys   = 0;
      m_xs    = 0;
      m_ys    = 0;
      m_x     = 0;
      m_y     = 0;
      m_pwd   = 1'b1;
      m_pvb   = 1'b0;
      m_first = 1'b1;
   endtask

   task automatic tick();
      exp_t e;
      bit   fw, fc;
      int   hs, vs;
      @(posedge clk);
      fc = 1'b0;
      if (!RESETn) begin
         model_reset();
      end else begin
         hs = FLIP ? 511 - int'(HN) : int'(HN);
         vs = FLIP ? 255 - int'(VN) : int'(VN);
         fw = !m_first && m_pwd && !cpu.WDn && !cpu.SCRSELn;
         fc = !m_first && !m_pvb && VBLANK;
         if (PIXCEN) begin
            m_x = (hs + m_xs) % 512;
            if (hs == 0) m_y = (vs + m_ys) % 256;
         end
         if (fc) begin
            m_xs = m_sxs;
            m_ys = m_sys;
         end
         if (fw) begin
            case (int'(cpu.AB))
               0: m_sxs = (m_sxs / 256) * 256 + int'(cpu.DB_in);
               1: m_sxs = (m_sxs % 256) + 256 * int'(cpu.DB_in[0]);
               2: m_sys = int'(cpu.DB_in);
               default: ;
            endcase
         end
         m_pwd   = cpu.WDn;
         m_pvb   = VBLANK;
         m_first = 1'b0;
      end
      e.x = m_x;
      e.y = m_y;
      e.c = int'(fc);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      exp_t e;
      #1;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL scoreboard_empty got=none want=entry");
      end else begin
         e = exp_q.pop_front();
         if (int'({DHPOS, HPOS, HFINE}) != e.x ||
             int'(DVPOS) != e.y || int'(COMMIT) != e.c) begin
            failures++;
            $display("FAIL mon t=%0t got x=%0h y=%0h c=%0d want x=%0h y=%0h c=%0d",
                     $time, {DHPOS, HPOS, HFINE}, DVPOS, COMMIT,
                     e.x, e.y, e.c);
         end
      end
   end

   task automatic wr(input logic [1:0] ab, input logic [7:0] d);
      cpu.SCRSELn = 1'b0;
      cpu.WDn     = 1'b0;
      cpu.AB      = ab;
      cpu.DB_in   = d;
      tick();
      cpu.WDn     = 1'b1;
      cpu.SCRSELn = 1'b1;
      tick();
   endtask

   task automatic vblank();
      VBLANK = 1'b1;
      tick();
      VBLANK = 1'b0;
      tick();
   endtask

   task automatic pix(input logic [8:0] h, input logic [7:0] v);
      PIXCEN = 1'b1;
      HN     = h;
      VN     = v;
      tick();
      PIXCEN = 1'b0;
   endtask

   initial begin
      RESETn      = 1'b0;
      PIXCEN      = 1'b0;
      HN          = '0;
      VN          = '0;
      VBLANK      = 1'b0;
      FLIP        = 1'b0;
      cpu.SCRSELn = 1'b1;
      cpu.WDn     = 1'b1;
      cpu.AB      = '0;
      cpu.DB_in   = '0;
      model_reset();

      // Toggle everything while in reset.
      for (int i = 0; i < 6; i++) begin
         PIXCEN      = 1'($urandom);
         HN          = 9'($urandom);
         VN          = 8'($urandom);
         VBLANK      = 1'(i);
         cpu.WDn     = 1'(i);
         cpu.SCRSELn = 1'b0;
         tick();
      end
      chk("reset_commit", int'(COMMIT), 0);
      chk("reset_x", int'({DHPOS, HPOS, HFINE}), 0);

      // Release with write strobe low and VBLANK high.
      PIXCEN      = 1'b0;
      cpu.WDn     = 1'b0;
      cpu.SCRSELn = 1'b0;
      cpu.AB      = 2'd0;
      cpu.DB_in   = 8'h77;
      VBLANK      = 1'b1;
      RESETn      = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("release_no_commit", int'(COMMIT), 0);
      end
      VBLANK      = 1'b0;
      cpu.WDn     = 1'b1;
      cpu.SCRSELn = 1'b1;
      tick();
      vblank();
      pix(9'd0, 8'd0);
      chk("release_no_write_x", int'({DHPOS, HPOS, HFINE}), 0);

      // Write then commit.
      wr(2'd0, 8'h34);
      wr(2'd1, 8'h01);
      wr(2'd2, 8'h10);
      pix(9'd0, 8'h20);
      chk("pre_vblank_dhpos", int'(DHPOS), 0);
      chk("pre_vblank_dvpos", int'(DVPOS), 8'h20);
      VBLANK = 1'b1;
      tick();
      chk("commit_pulse", int'(COMMIT), 1);
      VBLANK = 1'b0;
      tick();
      chk("commit_one_clk", int'(COMMIT), 0);
      pix(9'd0, 8'h20);
      chk("scroll_dhpos", int'(DHPOS), 8'h26);
      chk("scroll_hpos", int'(HPOS), 2);
      chk("scroll_hfine", int'(HFINE), 0);
      chk("scroll_dvpos", int'(DVPOS), 8'h30);

      // Wrap-around.
      wr(2'd0, 8'hFF);
      wr(2'd1, 8'h01);
      wr(2'd2, 8'hFF);
      vblank();
      pix(9'd1, 8'd1);
      chk("wrap_x", int'({DHPOS, HPOS, HFINE}), 0);
      pix(9'd0, 8'd1);
      chk("wrap_y", int'(DVPOS), 0);

      // Long strobe, data changes while WDn stays low.
      cpu.SCRSELn = 1'b0;
      cpu.WDn     = 1'b0;
      cpu.AB      = 2'd2;
      cpu.DB_in   = 8'h11;
      tick();
      cpu.DB_in = 8'h22;
      for (int i = 0; i < 9; i++) tick();
      cpu.WDn     = 1'b1;
      cpu.SCRSELn = 1'b1;
      tick();
      vblank();
      pix(9'd0, 8'd0);
      chk("long_strobe_y", int'(DVPOS), 8'h11);

      // Write colliding with the VBLANK edge.
      wr(2'd2, 8'h44);
      vblank();
      cpu.SCRSELn = 1'b0;
      cpu.WDn     = 1'b0;
      cpu.AB      = 2'd2;
      cpu.DB_in   = 8'h55;
      VBLANK      = 1'b1;
      tick();
      cpu.WDn     = 1'b1;
      cpu.SCRSELn = 1'b1;
      VBLANK      = 1'b0;
      tick();
      pix(9'd0, 8'd0);
      chk("collision_old", int'(DVPOS), 8'h44);
      vblank();
      pix(9'd0, 8'd0);
      chk("collision_new", int'(DVPOS), 8'h55);

      // Flip with zero X scroll.
      wr(2'd0, 8'h00);
      wr(2'd1, 8'h00);
      vblank();
      FLIP = 1'b1;
      pix(9'd0, 8'd0);
      chk("flip_dhpos", int'(DHPOS), 8'h3F);
      chk("flip_hpos", int'(HPOS), 3);
      chk("flip_hfine", int'(HFINE), 1);
      FLIP = 1'b0;

      // Line latch: Y holds while HN is mid-line.
      pix(9'd0, 8'h10);
      pix(9'd5, 8'h90);
      chk("latch_hold", int'(DVPOS), 8'h65);
      pix(9'd0, 8'h90);
      chk("latch_update", int'(DVPOS), 8'hE5);

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         PIXCEN      = 1'($urandom_range(0, 1));
         HN          = ($urandom_range(0, 3) == 0) ? 9'd0 : 9'($urandom);
         VN          = 8'($urandom);
         FLIP        = ($urandom_range(0, 7) == 0);
         cpu.WDn     = ($urandom_range(0, 2) != 0);
         cpu.SCRSELn = ($urandom_range(0, 3) == 0);
         cpu.AB      = 2'($urandom);
         cpu.DB_in   = 8'($urandom);
         if ($urandom_range(0, 15) == 0) VBLANK = ~VBLANK;
         if (FLIP && $urandom_range(0, 1) == 1) HN = 9'h1FF;
         tick();
      end

      // Asynchronous reset in mid-cycle.
      #2 RESETn = 1'b0;
      #1;
      chk("async_reset_x", int'({DHPOS, HPOS, HFINE}), 0);
      chk("async_reset_y", int'(DVPOS), 0);
      tick();
      PIXCEN = 1'b0;
      VBLANK = 1'b0;
      cpu.WDn = 1'b1;
      RESETn = 1'b1;
      tick();
      vblank();
      pix(9'h0AB, 8'h0);
      chk("post_reset_scroll", int'({DHPOS, HPOS, HFINE}), 9'h0AB);

      tick();
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
